// File: rtl/if_stage_pkg.sv
// Shared fetch/decode pipeline definitions.
// Widths, reset defaults and the fetch-to-decode payload.
package if_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_id_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO buffering fetched {instr, pc} pairs.
// Flush empties it in one cycle; head is read combinationally.
import if_stage_pkg::*;

module fetch_fifo #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  if_id_t        data_i,
    output if_id_t        head_o,
    output logic [AW:0]   count_o
);

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    if_id_t        mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign pop_ok  = pop_i & (cnt_q != '0);
    assign push_ok = push_i & ((cnt_q != (AW+1)'(DEPTH)) | pop_ok);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + 1'b1;
            if (pop_ok)  rd_d = rd_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited
// reads to a 1-cycle imem and hands {instr, pc} to decode.
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_instr,
    output logic [31:0] out_PC,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tag_q;
    logic         inflight_q;
    logic         kill_q;
    logic [CW-1:0] count;
    logic [CW:0]  occ;
    logic         flush_act;
    logic         pop;
    logic         push;
    if_id_t       head;
    if_id_t       resp;

    assign flush_act = flush & (state_q != ST_BOOT);
    assign out_valid = (count != '0) & ~flush;
    assign pop       = out_valid & out_ready;

    assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    assign imem_req  = (state_q == ST_RUN) & ~flush
                     & (occ < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = pc_q;

    assign push       = inflight_q & ~kill_q & ~flush_act;
    assign resp.instr = imem_rdata;
    assign resp.pc    = tag_q;
    assign out_instr  = head.instr;
    assign out_PC     = head.pc;

    // FSM next state and PC update; flush redirect beats increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (!flush && halt) state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
        if (flush_act)     pc_d = {redirect_pc[31:2], 2'b00};
        else if (imem_req) pc_d = pc_q + 32'd4;
    end

    // State, PC, in-flight tracking and response tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            kill_q     <= flush_act;
            if (imem_req) tag_q <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush_act),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (resp),
        .head_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table for the
// stream/backpressure phase, then flush, halt and reset sequences.
module tb_if_stage;

    localparam logic [31:0] XK   = 32'hA5A5_A5A5;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_ready;

    logic [31:0] imem_addr, imem_rdata, out_instr, out_PC;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr1, imem_rdata1, out_instr1, out_PC1;
    logic        imem_req1, out_valid1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata  <= imem_addr ^ XK;
        imem_rdata1 <= imem_addr1 ^ XK;
    end

    if_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .out_instr   (out_instr),
        .out_PC      (out_PC),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    if_stage #(.RESET_PC(RPC1)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr1),
        .imem_req    (imem_req1),
        .imem_rdata  (imem_rdata1),
        .out_instr   (out_instr1),
        .out_PC      (out_PC1),
        .out_valid   (out_valid1),
        .out_ready   (out_ready)
    );

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic fl,
                       input logic [31:0] rpc, input logic hl);
        @(negedge clk);
        out_ready   = rdy;
        flush       = fl;
        redirect_pc = rpc;
        halt        = hl;
        #1;
    endtask

    task automatic chk_head(input string nm, input logic [31:0] pc);
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".pc"}, out_PC, pc);
        chk({nm, ".instr"}, out_instr, pc ^ XK);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
        tbl[4]  = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
        tbl[5]  = '{1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
        tbl[6]  = '{1'b0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[7]  = '{1'b0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[8]  = '{1'b0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[9]  = '{1'b0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[10] = '{1'b0, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[11] = '{1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[12] = '{1'b1, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0010};
        tbl[13] = '{1'b1, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0014};
        tbl[14] = '{1'b1, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0018};

        rst = 1'b1;
        flush = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.addr", imem_addr, 32'h8000_0000);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.pc", out_PC, 32'd0);
        chk("rst.addr_wrap", imem_addr1, RPC1);

        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k != 0) cyc(tbl[k].rdy, 1'b0, 32'h0, 1'b0);
            else #1;
            chk($sformatf("v%0d.req", k), 32'(imem_req), 32'(tbl[k].req));
            if (tbl[k].req)
                chk($sformatf("v%0d.addr", k), imem_addr, tbl[k].addr);
            chk($sformatf("v%0d.valid", k), 32'(out_valid), 32'(tbl[k].vld));
            if (tbl[k].vld) begin
                chk($sformatf("v%0d.pc", k), out_PC, tbl[k].pc);
                chk($sformatf("v%0d.instr", k), out_instr, tbl[k].pc ^ XK);
            end
            if (k >= 3 && k <= 5)
                chk($sformatf("wrap%0d.pc", k), out_PC1,
                    RPC1 + 32'(4 * (k - 3)));
        end

        cyc(1'b1, 1'b1, 32'h8000_0103, 1'b0);
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.req", 32'(imem_req), 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("fl1.valid", 32'(out_valid), 32'd0);
        chk("fl1.req", 32'(imem_req), 32'd1);
        chk("fl1.addr", imem_addr, 32'h8000_0100);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("fl2.valid", 32'(out_valid), 32'd0);
        chk("fl2.addr", imem_addr, 32'h8000_0104);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk_head("fl3", 32'h8000_0100);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk_head("fl4", 32'h8000_0104);

        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("h0.req", 32'(imem_req), 32'd1);
        chk("h0.addr", imem_addr, 32'h8000_0110);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("h1.req", 32'(imem_req), 32'd0);
        chk_head("h1", 32'h8000_010C);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("h2.req", 32'(imem_req), 32'd0);
        chk_head("h2", 32'h8000_0110);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("h3.req", 32'(imem_req), 32'd0);
        chk("h3.valid", 32'(out_valid), 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("h4.req", 32'(imem_req), 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("h5.req", 32'(imem_req), 32'd1);
        chk("h5.addr", imem_addr, 32'h8000_0114);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("h6.addr", imem_addr, 32'h8000_0118);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk_head("h7", 32'h8000_0114);

        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("f0.req", 32'(imem_req), 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("f1.req", 32'(imem_req), 32'd0);
        chk_head("f1", 32'h8000_0118);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.valid", 32'(out_valid), 32'd0);
        chk("ar.req", 32'(imem_req), 32'd0);
        chk("ar.addr", imem_addr, 32'h8000_0000);
        chk("ar.pc", out_PC, 32'd0);
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("rr0.req", 32'(imem_req), 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rr1.req", 32'(imem_req), 32'd1);
        chk("rr1.addr", imem_addr, 32'h8000_0000);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk_head("rr3", 32'h8000_0000);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk_head("rr4", 32'h8000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
